// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
// Defaults match the CPU datapath: 16 x 16-bit registers, rs1/rs2 read ports.
package rf_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_NREG  = 16;
    localparam int RF_NRD   = 2;
    localparam int RF_SEL   = $clog2(RF_NREG);
    localparam int R0_IDX   = 0;

    typedef logic [RF_WIDTH-1:0] rf_word_t;
    typedef logic [RF_SEL-1:0]   rf_sel_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range check, optional write bypass, busy check.
// Data is held whenever the port does not return a valid word.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int NREG   = RF_NREG,
    parameter int SEL    = $clog2(NREG),
    parameter bit BYPASS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [SEL-1:0]        sel_i,
    input  logic [NREG*WIDTH-1:0] words_i,
    input  logic [NREG-1:0]       busy_i,
    input  logic                  wr_en_i,
    input  logic [SEL-1:0]        wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o
);

    localparam logic [SEL:0] NREG_W = (SEL+1)'(NREG);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (req_i) begin
            if ({1'b0, sel_i} >= NREG_W) begin
                // Unimplemented selects read as a valid zero rather than stalling.
                data_d  = '0;
                valid_d = 1'b1;
            end else if (BYPASS && wr_en_i && (wr_addr_i == sel_i)) begin
                data_d  = wr_data_i;
                valid_d = 1'b1;
            end else if (!busy_i[sel_i]) begin
                data_d  = words_i[int'(sel_i)*WIDTH +: WIDTH];
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with busy scoreboard and NRD registered read ports.
// Define RF_BYPASS_EN to forward same-edge writeback data to matching reads.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int WIDTH   = RF_WIDTH,
    parameter int NREG    = RF_NREG,
    parameter int SEL     = $clog2(NREG),
    parameter int NRD     = RF_NRD,
    parameter int R0_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [SEL-1:0]       wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rsv_en,
    input  logic [SEL-1:0]       rsv_addr,
    input  logic [NRD-1:0]       rd_req,
    input  logic [NRD*SEL-1:0]   rd_sel,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid,
    output logic [NREG-1:0]      busy
);

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [SEL:0]   NREG_W = (SEL+1)'(NREG);
    localparam logic [SEL-1:0] R0_SEL = SEL'(R0_IDX);

    logic [WIDTH-1:0]      regs_q [NREG];
    logic [NREG*WIDTH-1:0] words_flat;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  wr_eff, rsv_eff;

    // Register 0 and out-of-range addresses silently drop writes and reservations.
    assign wr_eff  = wr_en && ({1'b0, wr_addr} < NREG_W)
                     && !((R0_ZERO != 0) && (wr_addr == R0_SEL));
    assign rsv_eff = rsv_en && ({1'b0, rsv_addr} < NREG_W)
                     && !((R0_ZERO != 0) && (rsv_addr == R0_SEL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_eff) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Reserve is applied after the write clear so a new producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_eff) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_eff) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
        assign words_flat[gi*WIDTH +: WIDTH] = regs_q[gi];
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
        rf_read_port #(
            .WIDTH  (WIDTH),
            .NREG   (NREG),
            .SEL    (SEL),
            .BYPASS (BYPASS)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .req_i     (rd_req[gi]),
            .sel_i     (rd_sel[gi*SEL +: SEL]),
            .words_i   (words_flat),
            .busy_i    (busy_q),
            .wr_en_i   (wr_eff),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .data_o    (rd_data[gi*WIDTH +: WIDTH]),
            .valid_o   (rd_valid[gi])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios, then random traffic
// checked against a register/scoreboard model built from the operating rules.
module tb_reg_file_mp;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [1:0]  rd_req;
    logic [7:0]  rd_sel;
    logic [31:0] rd_data;
    logic [1:0]  rd_valid;
    logic [15:0] busy;

    int n_assert = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference model state
    logic [15:0] m_mem  [16];
    logic        m_busy [16];
    logic [15:0] m_data [2];
    logic        m_valid[2];

    reg_file_mp dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            m_data[p]  = '0;
            m_valid[p] = 1'b0;
        end
    endtask

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic [3:0] s;
        bit wr_ok;
        bit bypass;
`ifdef RF_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        wr_ok = wr_en && (wr_addr != 4'd0);
        for (int p = 0; p < 2; p++) begin
            s = rd_sel[p*4 +: 4];
            m_valid[p] = 1'b0;
            if (rd_req[p]) begin
                if (s == 4'd0) begin
                    m_data[p]  = 16'h0;
                    m_valid[p] = 1'b1;
                end else if (bypass && wr_ok && wr_addr == s) begin
                    m_data[p]  = wr_data;
                    m_valid[p] = 1'b1;
                end else if (!m_busy[s]) begin
                    m_data[p]  = m_mem[s];
                    m_valid[p] = 1'b1;
                end
            end
        end
        if (wr_ok) begin
            m_mem[wr_addr]  = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 4'd0) begin
            m_busy[rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] exp_busy;
        for (int i = 0; i < 16; i++) exp_busy[i] = m_busy[i];
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s.valid%0d", tag, p), 32'(rd_valid[p]), 32'(m_valid[p]));
            chk($sformatf("%s.data%0d", tag, p), 32'(rd_data[p*16 +: 16]), 32'(m_data[p]));
        end
        chk($sformatf("%s.busy", tag), 32'(busy), 32'(exp_busy));
    endtask

    // Drive one transaction at the falling edge, clock it, check 1 ns after the edge.
    task automatic step(input string tag, input logic we, input logic [3:0] wa,
                        input logic [15:0] wd, input logic re, input logic [3:0] ra,
                        input logic [1:0] rq, input logic [3:0] s0, input logic [3:0] s1);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        rd_req = rq; rd_sel = {s1, s0};
        @(posedge clk);
        model_edge();
        #1;
        n_txn++;
        $display("txn %0d %s: we=%b wa=%0d wd=%h re=%b ra=%0d rq=%b s0=%0d s1=%0d -> v=%b d0=%h d1=%h busy=%h",
                 n_txn, tag, we, wa, wd, re, ra, rq, s0, s1, rd_valid,
                 rd_data[15:0], rd_data[31:16], busy);
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 2'b00, 4'd0, 4'd0);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; rd_req = '0; rd_sel = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.valid", 32'(rd_valid), 32'h0);
        chk("reset.data", rd_data, 32'h0);
        chk("reset.busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Write then read next cycle
        step("wr3", 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 2'b00, 4'd0, 4'd0);
        step("rd3", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 2'b01, 4'd3, 4'd0);
        chk("rd3.exp_valid", 32'(rd_valid[0]), 32'h1);
        chk("rd3.exp_data", 32'(rd_data[15:0]), 32'h1234);

        // Reserve blocks reads until writeback
        step("rsv5", 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 2'b00, 4'd0, 4'd0);
        step("rd5busy", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 2'b01, 4'd5, 4'd0);
        chk("rd5busy.exp_valid", 32'(rd_valid[0]), 32'h0);
        chk("rd5busy.exp_held", 32'(rd_data[15:0]), 32'h1234);
        step("wr5", 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 2'b00, 4'd0, 4'd0);
        step("rd5", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 2'b01, 4'd5, 4'd0);
        chk("rd5.exp_valid", 32'(rd_valid[0]), 32'h1);
        chk("rd5.exp_data", 32'(rd_data[15:0]), 32'hBEEF);
        chk("rd5.busy5", 32'(busy[5]), 32'h0);

        // Same-edge write and read of a non-busy register
        step("wr7", 1'b1, 4'd7, 16'h0011, 1'b0, 4'd0, 2'b00, 4'd0, 4'd0);
        step("wrrd7", 1'b1, 4'd7, 16'h00AA, 1'b0, 4'd0, 2'b01, 4'd7, 4'd0);
        chk("wrrd7.exp_valid", 32'(rd_valid[0]), 32'h1);
`ifdef RF_BYPASS_EN
        chk("wrrd7.exp_data", 32'(rd_data[15:0]), 32'h00AA);
`else
        chk("wrrd7.exp_data", 32'(rd_data[15:0]), 32'h0011);
`endif
        step("rd7", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 2'b10, 4'd0, 4'd7);
        chk("rd7.exp_data", 32'(rd_data[31:16]), 32'h00AA);

        // Register 0 ignores writes and reservations
        step("wr0", 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 2'b00, 4'd0, 4'd0);
        step("rd0", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 2'b11, 4'd0, 4'd0);
        chk("rd0.exp_valid", 32'(rd_valid), 32'h3);
        chk("rd0.exp_data", rd_data, 32'h0);
        chk("rd0.busy0", 32'(busy[0]), 32'h0);

        // Both ports on reg2 while reg9 is written and re-reserved together
        step("wr2", 1'b1, 4'd2, 16'h2222, 1'b0, 4'd0, 2'b00, 4'd0, 4'd0);
        step("both2", 1'b1, 4'd9, 16'h9999, 1'b1, 4'd9, 2'b11, 4'd2, 4'd2);
        chk("both2.exp_valid", 32'(rd_valid), 32'h3);
        chk("both2.exp_data", rd_data, 32'h2222_2222);
        chk("both2.busy9", 32'(busy[9]), 32'h1);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            step("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 16'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        // Reset asserted mid-read takes effect without waiting for a clock edge
        step("prerst", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 2'b01, 4'd3, 4'd0);
        @(negedge clk);
        rd_req = 2'b01; rd_sel = 8'h03;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst.valid", 32'(rd_valid), 32'h0);
        chk("midrst.data", rd_data, 32'h0);
        chk("midrst.busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 1; r < 16; r++) begin
            step("postrst", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 2'b11, 4'(r), 4'(16 - r));
            chk("postrst.zero", rd_data, 32'h0);
        end
        idle("tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
